// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RV64 divider.
package div_pkg;

  localparam int XLEN_ITERS = 64;
  localparam int WORD_ITERS = 32;

  localparam logic [63:0] DIV0_QUO = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN_S64  = 64'h8000_0000_0000_0000;
  localparam logic [31:0] MIN_S32  = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Word-op results are always delivered sign-extended to 64 bits.
  function automatic logic [63:0] sext32(input logic [31:0] value);
    return {{32{value[31]}}, value};
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step on an unsigned {rem, quo} pair.
module div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] rem_shift;
  logic [XLEN:0] trial;

  // Shift in the next dividend bit and keep the difference only when it does not borrow.
  always_comb begin
    rem_shift = {rem, quo[XLEN-1]};
    trial     = rem_shift - {1'b0, divisor};
    if (trial[XLEN]) begin
      rem_next = rem_shift[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b0};
    end else begin
      rem_next = trial[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 divider for DIV/DIVU/REM/REMU and their W variants.
module div_unit
  import div_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            op_rem,
  input  logic            is_unsign,
  input  logic            is_word,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  div_state_e        state;
  logic [CNT_W-1:0]  counter;
  logic [XLEN-1:0]   rem_q;
  logic [XLEN-1:0]   quo_q;
  logic [XLEN-1:0]   divisor_q;
  logic              neg_quo;
  logic              neg_rem;
  logic              is_word_q;
  logic              op_rem_q;

  logic [XLEN-1:0]   a_ext;
  logic [XLEN-1:0]   b_ext;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [XLEN-1:0]   quo_init;
  logic              div_zero;
  logic              overflow;
  logic [XLEN-1:0]   special_result;

  logic [XLEN-1:0]   step_rem;
  logic [XLEN-1:0]   step_quo;
  logic [CNT_W-1:0]  last_count;
  logic [31:0]       quo32;
  logic [31:0]       rem32;
  logic [XLEN-1:0]   quo64;
  logic [XLEN-1:0]   rem64;
  logic [XLEN-1:0]   fixed_result;

  // Operand preparation: width selection, magnitudes, signs and special-case detection.
  always_comb begin
    if (is_word) begin
      a_ext = is_unsign ? {32'b0, data1[31:0]} : sext32(data1[31:0]);
      b_ext = is_unsign ? {32'b0, data2[31:0]} : sext32(data2[31:0]);
    end else begin
      a_ext = data1;
      b_ext = data2;
    end

    a_neg = ~is_unsign & a_ext[XLEN-1];
    b_neg = ~is_unsign & b_ext[XLEN-1];
    a_mag = a_neg ? (~a_ext + 1'b1) : a_ext;
    b_mag = b_neg ? (~b_ext + 1'b1) : b_ext;

    // Word dividends sit in the top half so 32 steps leave the quotient in the low half.
    quo_init = is_word ? {a_mag[31:0], {(XLEN-32){1'b0}}} : a_mag;

    div_zero = (b_ext == '0);
    if (is_word) begin
      overflow = ~is_unsign && (data1[31:0] == MIN_S32) && (data2[31:0] == 32'hFFFF_FFFF);
    end else begin
      overflow = ~is_unsign && (data1 == MIN_S64) && (data2 == DIV0_QUO);
    end

    if (div_zero) begin
      if (op_rem) begin
        special_result = is_word ? sext32(data1[31:0]) : data1;
      end else begin
        special_result = DIV0_QUO;
      end
    end else begin
      special_result = op_rem ? '0 : a_ext;
    end
  end

  div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (divisor_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  // Sign fix and word extension applied to the outcome of the final step.
  always_comb begin
    last_count = is_word_q ? CNT_W'(WORD_ITERS - 1) : CNT_W'(XLEN_ITERS - 1);

    quo32 = neg_quo ? (~step_quo[31:0] + 32'd1) : step_quo[31:0];
    rem32 = neg_rem ? (~step_rem[31:0] + 32'd1) : step_rem[31:0];
    quo64 = neg_quo ? (~step_quo + 1'b1) : step_quo;
    rem64 = neg_rem ? (~step_rem + 1'b1) : step_rem;

    if (is_word_q) begin
      fixed_result = op_rem_q ? sext32(rem32) : sext32(quo32);
    end else begin
      fixed_result = op_rem_q ? rem64 : quo64;
    end
  end

  // Control FSM with registered handshake outputs; flush wins over accept and response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      counter    <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      divisor_q  <= '0;
      neg_quo    <= 1'b0;
      neg_rem    <= 1'b0;
      is_word_q  <= 1'b0;
      op_rem_q   <= 1'b0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
      result     <= '0;
    end else if (flush) begin
      state      <= IDLE;
      counter    <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            counter   <= '0;
            neg_quo   <= a_neg ^ b_neg;
            neg_rem   <= a_neg;
            is_word_q <= is_word;
            op_rem_q  <= op_rem;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (div_zero || overflow) begin
              state      <= DONE;
              result     <= special_result;
              resp_valid <= 1'b1;
            end else begin
              state     <= CALC;
              rem_q     <= '0;
              quo_q     <= quo_init;
              divisor_q <= b_mag;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        CALC: begin
          rem_q   <= step_rem;
          quo_q   <= step_quo;
          counter <= counter + 1'b1;
          if (counter == last_count) begin
            state      <= DONE;
            result     <= fixed_result;
            resp_valid <= 1'b1;
          end
        end
        DONE: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed test-plan cases, random cases, flush and reset.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        op_rem;
  logic        is_unsign;
  logic        is_word;
  logic [63:0] data1;
  logic [63:0] data2;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] result;
  logic        busy;

  logic [63:0] exp_res_q[$];
  int          exp_lat_q[$];
  string       exp_name_q[$];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  div_unit #(.XLEN(64), .CNT_W(7)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .op_rem     (op_rem),
    .is_unsign  (is_unsign),
    .is_word    (is_word),
    .data1      (data1),
    .data2      (data2),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .result     (result),
    .busy       (busy)
  );

  // Reference RISC-V division semantics, including divide-by-zero and overflow.
  function automatic logic [63:0] refDiv(input logic rem, input logic uns, input logic word,
                                         input logic [63:0] a, input logic [63:0] b);
    logic [31:0]        r32;
    logic signed [31:0] sa32;
    logic signed [31:0] sb32;
    logic signed [63:0] sa64;
    logic signed [63:0] sb64;
    if (word) begin
      sa32 = a[31:0];
      sb32 = b[31:0];
      if (b[31:0] == 32'd0)
        r32 = rem ? a[31:0] : 32'hFFFF_FFFF;
      else if (!uns && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
        r32 = rem ? 32'd0 : a[31:0];
      else if (uns)
        r32 = rem ? (a[31:0] % b[31:0]) : (a[31:0] / b[31:0]);
      else
        r32 = rem ? (sa32 % sb32) : (sa32 / sb32);
      return {{32{r32[31]}}, r32};
    end
    sa64 = a;
    sb64 = b;
    if (b == 64'd0)
      return rem ? a : 64'hFFFF_FFFF_FFFF_FFFF;
    if (!uns && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)
      return rem ? 64'd0 : a;
    if (uns)
      return rem ? (a % b) : (a / b);
    return rem ? (sa64 % sb64) : (sa64 / sb64);
  endfunction

  // Expected accept-to-response latency in cycles.
  function automatic int refLat(input logic uns, input logic word,
                                input logic [63:0] a, input logic [63:0] b);
    if (word) begin
      if (b[31:0] == 32'd0) return 1;
      if (!uns && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
      return 33;
    end
    if (b == 64'd0) return 1;
    if (!uns && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) return 1;
    return 65;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected)
      passes++;
    else
      $display("[TB] FAIL %s: got 0x%h expected 0x%h", tag, actual, expected);
  endtask

  // Waits for req_ready at a falling edge, drives one request and records its expectation.
  task automatic applyStimulus(input string name, input logic rem, input logic uns, input logic word,
                               input logic [63:0] a, input logic [63:0] b, input int lat);
    int waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) checkOutput({name, "_req_ready_wait"}, 64'(req_ready), 64'd1);
    op_rem    = rem;
    is_unsign = uns;
    is_word   = word;
    data1     = a;
    data2     = b;
    req_valid = 1'b1;
    exp_res_q.push_back(refDiv(rem, uns, word, a, b));
    exp_lat_q.push_back(lat);
    exp_name_q.push_back(name);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Counts cycles since accept, pops the scoreboard, optionally stalls, then handshakes.
  task automatic collectResponse(input int hold);
    int          k = 1;
    logic [63:0] exp_res;
    int          exp_lat;
    string       name;
    @(negedge clk);
    while (!resp_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    exp_res = exp_res_q.pop_front();
    exp_lat = exp_lat_q.pop_front();
    name    = exp_name_q.pop_front();
    checkOutput({name, "_latency"}, 64'(k), 64'(exp_lat));
    checkOutput({name, "_result"}, result, exp_res);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput({name, "_hold_result"}, result, exp_res);
      checkOutput({name, "_hold_valid"}, 64'(resp_valid), 64'd1);
      checkOutput({name, "_hold_req_ready"}, 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    checkOutput({name, "_idle_busy"}, 64'(busy), 64'd0);
    checkOutput({name, "_idle_req_ready"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rrem;
    logic        runs;
    logic        rword;
    int          rv_seen;
    int          busy_seen;

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    op_rem     = 1'b0;
    is_unsign  = 1'b0;
    is_word    = 1'b0;
    data1      = '0;
    data2      = '0;
    flush      = 1'b0;
    resp_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("reset_result", result, 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_req_ready", 64'(req_ready), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_req_ready", 64'(req_ready), 64'd1);

    applyStimulus("divu_100_7", 1'b0, 1'b1, 1'b0, 64'd100, 64'd7, 65);
    collectResponse(0);
    applyStimulus("remu_100_7", 1'b1, 1'b1, 1'b0, 64'd100, 64'd7, 65);
    collectResponse(0);
    applyStimulus("div_m7_2", 1'b0, 1'b0, 1'b0, -64'sd7, 64'd2, 65);
    collectResponse(0);
    applyStimulus("rem_m7_2", 1'b1, 1'b0, 1'b0, -64'sd7, 64'd2, 65);
    collectResponse(0);
    applyStimulus("divu_by0", 1'b0, 1'b1, 1'b0, 64'h1234, 64'd0, 1);
    collectResponse(0);
    applyStimulus("rem_by0", 1'b1, 1'b0, 1'b0, 64'h1234, 64'd0, 1);
    collectResponse(0);
    applyStimulus("div_ovf", 1'b0, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    collectResponse(0);
    applyStimulus("rem_ovf", 1'b1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    collectResponse(0);
    applyStimulus("divw_ovf", 1'b0, 1'b0, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    collectResponse(0);
    applyStimulus("divuw_ext", 1'b0, 1'b1, 1'b1, 64'hDEAD_0000_8000_0000, 64'd1, 33);
    collectResponse(0);
    applyStimulus("remw_m9_4", 1'b1, 1'b0, 1'b1, -64'sd9, 64'd4, 33);
    collectResponse(0);
    applyStimulus("divu_backpressure", 1'b0, 1'b1, 1'b0, 64'd100, 64'd7, 65);
    collectResponse(5);

    for (int i = 0; i < 8; i++) begin
      ra    = {$urandom, $urandom};
      rb    = {$urandom, $urandom} >> $urandom_range(0, 60);
      rrem  = 1'($urandom_range(0, 1));
      runs  = 1'($urandom_range(0, 1));
      rword = 1'($urandom_range(0, 1));
      applyStimulus("random", rrem, runs, rword, ra, rb, refLat(runs, rword, ra, rb));
      collectResponse(0);
    end

    // Flush at cycle N+10 of a 64-bit DIVU.
    @(negedge clk);
    op_rem = 1'b0; is_unsign = 1'b1; is_word = 1'b0;
    data1 = 64'd1000; data2 = 64'd3; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_busy", 64'(busy), 64'd0);
    checkOutput("flush_req_ready", 64'(req_ready), 64'd1);
    checkOutput("flush_resp_valid", 64'(resp_valid), 64'd0);
    rv_seen = 0;
    busy_seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (resp_valid) rv_seen++;
      if (busy) busy_seen++;
    end
    checkOutput("flush_no_resp", 64'(rv_seen), 64'd0);
    checkOutput("flush_stays_idle", 64'(busy_seen), 64'd0);

    // A request coinciding with flush is dropped.
    req_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1 begin req_valid = 1'b0; flush = 1'b0; end
    @(negedge clk);
    checkOutput("flush_req_dropped_busy", 64'(busy), 64'd0);
    checkOutput("flush_req_dropped_ready", 64'(req_ready), 64'd1);

    applyStimulus("divu_after_flush", 1'b0, 1'b1, 1'b0, 64'd100, 64'd7, 65);
    collectResponse(0);

    // Reset in the middle of CALC.
    @(negedge clk);
    op_rem = 1'b0; is_unsign = 1'b1; is_word = 1'b0;
    data1 = 64'd5000; data2 = 64'd9; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkOutput("mid_calc_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("midrst_result", result, 64'd0);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_req_ready", 64'(req_ready), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_release_req_ready", 64'(req_ready), 64'd1);

    applyStimulus("remu_after_reset", 1'b1, 1'b1, 1'b0, 64'd5000, 64'd9, 65);
    collectResponse(0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
